// File: rtl/decode_cycle_if.sv
// Fetch/writeback inputs and D/E pipeline outputs of the RV32I decode stage.
// The master modport is the surrounding pipeline; the decode stage uses the slave modport.
interface decode_cycle_if #(
    parameter int unsigned XLEN = 32
);

    // Fetch stage and hazard inputs
    logic [31:0]     instrD;
    logic [XLEN-1:0] pcD;
    logic [XLEN-1:0] pcplus4D;
    logic            flushE;

    // Writeback port
    logic            regwriteW;
    logic [4:0]      rdW;
    logic [XLEN-1:0] resultW;

    // D/E pipeline register
    logic            regwriteE;
    logic [1:0]      resultsrcE;
    logic            memwriteE;
    logic            jumpE;
    logic            branchE;
    logic [2:0]      alucontrolE;
    logic            alusrcE;
    logic [XLEN-1:0] rd1E;
    logic [XLEN-1:0] rd2E;
    logic [XLEN-1:0] immextE;
    logic [4:0]      rs1E;
    logic [4:0]      rs2E;
    logic [4:0]      rdE;
    logic [XLEN-1:0] pcE;
    logic [XLEN-1:0] pcplus4E;

    modport master (
        output instrD, pcD, pcplus4D, flushE,
        output regwriteW, rdW, resultW,
        input  regwriteE, resultsrcE, memwriteE, jumpE, branchE, alucontrolE, alusrcE,
        input  rd1E, rd2E, immextE, rs1E, rs2E, rdE, pcE, pcplus4E
    );

    modport slave (
        input  instrD, pcD, pcplus4D, flushE,
        input  regwriteW, rdW, resultW,
        output regwriteE, resultsrcE, memwriteE, jumpE, branchE, alucontrolE, alusrcE,
        output rd1E, rd2E, immextE, rs1E, rs2E, rdE, pcE, pcplus4E
    );

endinterface

// File: rtl/decode_cycle.sv
// RV32I decode stage: register file with write-through bypass, main/ALU decoders,
// immediate extender and the D/E pipeline register with flush.
module decode_cycle #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input logic           clk,
    input logic           rst,
    decode_cycle_if.slave bus
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [2:0] ImmNone = 3'd0;
    localparam logic [2:0] ImmI    = 3'd1;
    localparam logic [2:0] ImmS    = 3'd2;
    localparam logic [2:0] ImmB    = 3'd3;
    localparam logic [2:0] ImmJ    = 3'd4;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    // Instruction fields
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;

    assign instr    = bus.instrD;
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rd       = instr[11:7];

    // Register file; entry 0 is never written so it reads back as zero after reset.
    logic [XLEN-1:0] regsQ [NREG];
    logic            wrEn;

    assign wrEn = bus.regwriteW && (bus.rdW != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regsQ[i] <= '0;
            end
        end else if (wrEn) begin
            regsQ[bus.rdW] <= bus.resultW;
        end
    end

    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    // Same-cycle writeback is forwarded so the D/E register never captures stale data.
    always_comb begin
        rd1 = regsQ[rs1];
        if (rs1 == 5'd0) begin
            rd1 = '0;
        end else if (wrEn && (bus.rdW == rs1)) begin
            rd1 = bus.resultW;
        end
    end

    always_comb begin
        rd2 = regsQ[rs2];
        if (rs2 == 5'd0) begin
            rd2 = '0;
        end else if (wrEn && (bus.rdW == rs2)) begin
            rd2 = bus.resultW;
        end
    end

    // Main decoder
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       jump;
    logic       branch;
    logic       alusrc;
    logic [1:0] aluop;
    logic [2:0] immsrc;

    always_comb begin
        regwrite  = 1'b0;
        resultsrc = 2'b00;
        memwrite  = 1'b0;
        jump      = 1'b0;
        branch    = 1'b0;
        alusrc    = 1'b0;
        aluop     = 2'b00;
        immsrc    = ImmNone;
        case (opcode)
            OpLoad: begin
                regwrite  = 1'b1;
                resultsrc = 2'b01;
                alusrc    = 1'b1;
                immsrc    = ImmI;
            end
            OpStore: begin
                memwrite = 1'b1;
                alusrc   = 1'b1;
                immsrc   = ImmS;
            end
            OpRtype: begin
                regwrite = 1'b1;
                aluop    = 2'b10;
            end
            OpItype: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                immsrc   = ImmI;
                aluop    = 2'b10;
            end
            OpBranch: begin
                branch = 1'b1;
                immsrc = ImmB;
                aluop  = 2'b01;
            end
            OpJal: begin
                regwrite  = 1'b1;
                jump      = 1'b1;
                resultsrc = 2'b10;
                immsrc    = ImmJ;
            end
            default: begin
            end
        endcase
    end

    // ALU decoder
    logic [2:0] alucontrol;

    always_comb begin
        alucontrol = AluAdd;
        case (aluop)
            2'b01: alucontrol = AluSub;
            2'b10: begin
                case (funct3)
                    3'b000:  alucontrol = (opcode[5] && funct7b5) ? AluSub : AluAdd;
                    3'b010:  alucontrol = AluSlt;
                    3'b110:  alucontrol = AluOr;
                    3'b111:  alucontrol = AluAnd;
                    default: alucontrol = AluAdd;
                endcase
            end
            default: alucontrol = AluAdd;
        endcase
    end

    // Immediate extender
    logic [XLEN-1:0] immext;

    always_comb begin
        immext = '0;
        case (immsrc)
            ImmI: immext = {{(XLEN-12){instr[31]}}, instr[31:20]};
            ImmS: immext = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            ImmB: immext = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            ImmJ: immext = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: immext = '0;
        endcase
    end

    // D/E pipeline register
    logic            regwriteQ;
    logic [1:0]      resultsrcQ;
    logic            memwriteQ;
    logic            jumpQ;
    logic            branchQ;
    logic [2:0]      alucontrolQ;
    logic            alusrcQ;
    logic [XLEN-1:0] rd1Q;
    logic [XLEN-1:0] rd2Q;
    logic [XLEN-1:0] immextQ;
    logic [4:0]      rs1Q;
    logic [4:0]      rs2Q;
    logic [4:0]      rdQ;
    logic [XLEN-1:0] pcQ;
    logic [XLEN-1:0] pcplus4Q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwriteQ   <= 1'b0;
            resultsrcQ  <= 2'b00;
            memwriteQ   <= 1'b0;
            jumpQ       <= 1'b0;
            branchQ     <= 1'b0;
            alucontrolQ <= 3'b000;
            alusrcQ     <= 1'b0;
            rd1Q        <= '0;
            rd2Q        <= '0;
            immextQ     <= '0;
            rs1Q        <= 5'd0;
            rs2Q        <= 5'd0;
            rdQ         <= 5'd0;
            pcQ         <= '0;
            pcplus4Q    <= '0;
        end else if (bus.flushE) begin
            regwriteQ   <= 1'b0;
            resultsrcQ  <= 2'b00;
            memwriteQ   <= 1'b0;
            jumpQ       <= 1'b0;
            branchQ     <= 1'b0;
            alucontrolQ <= 3'b000;
            alusrcQ     <= 1'b0;
            rd1Q        <= '0;
            rd2Q        <= '0;
            immextQ     <= '0;
            rs1Q        <= 5'd0;
            rs2Q        <= 5'd0;
            rdQ         <= 5'd0;
            pcQ         <= '0;
            pcplus4Q    <= '0;
        end else begin
            regwriteQ   <= regwrite;
            resultsrcQ  <= resultsrc;
            memwriteQ   <= memwrite;
            jumpQ       <= jump;
            branchQ     <= branch;
            alucontrolQ <= alucontrol;
            alusrcQ     <= alusrc;
            rd1Q        <= rd1;
            rd2Q        <= rd2;
            immextQ     <= immext;
            rs1Q        <= rs1;
            rs2Q        <= rs2;
            rdQ         <= rd;
            pcQ         <= bus.pcD;
            pcplus4Q    <= bus.pcplus4D;
        end
    end

    assign bus.regwriteE   = regwriteQ;
    assign bus.resultsrcE  = resultsrcQ;
    assign bus.memwriteE   = memwriteQ;
    assign bus.jumpE       = jumpQ;
    assign bus.branchE     = branchQ;
    assign bus.alucontrolE = alucontrolQ;
    assign bus.alusrcE     = alusrcQ;
    assign bus.rd1E        = rd1Q;
    assign bus.rd2E        = rd2Q;
    assign bus.immextE     = immextQ;
    assign bus.rs1E        = rs1Q;
    assign bus.rs2E        = rs2Q;
    assign bus.rdE         = rdQ;
    assign bus.pcE         = pcQ;
    assign bus.pcplus4E    = pcplus4Q;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed scenarios plus randomized instructions
// compared against a behavioural model of the decode rules and register file.
module tb_decode_cycle;

    logic clk;
    logic rst;

    decode_cycle_if bus ();

    decode_cycle dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mregs [32];

    typedef struct packed {
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic        memwrite;
        logic        jump;
        logic        branch;
        logic [2:0]  aluctl;
        logic        alusrc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc4;
    } expT;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] readReg(input logic [4:0] rs, input logic we,
                                            input logic [4:0] wrd, input logic [31:0] wres);
        if (rs == 5'd0) return 32'h0;
        if (we && wrd == rs) return wres;
        return mregs[rs];
    endfunction

    function automatic logic [2:0] aluFromFunct(input logic [2:0] f3, input logic subBit);
        if (f3 == 3'b000) return subBit ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    function automatic expT predict(input logic [31:0] instr, input logic [31:0] pc,
                                    input logic flush, input logic we,
                                    input logic [4:0] wrd, input logic [31:0] wres);
        expT e;
        logic [31:0] sgn;
        logic [31:0] immI, immS, immB, immJ;
        e = '0;
        if (flush) return e;
        // Sign mask is all ones for negative instructions; fields are placed arithmetically.
        sgn  = (instr[31]) ? 32'hFFFF_FFFF : 32'h0;
        immI = (sgn << 12) | 32'(instr[31:20]);
        immS = (sgn << 12) | (32'(instr[31:25]) << 5) | 32'(instr[11:7]);
        immB = (sgn << 12) | (32'(instr[7]) << 11) | (32'(instr[30:25]) << 5)
             | (32'(instr[11:8]) << 1);
        immJ = (sgn << 20) | (32'(instr[19:12]) << 12) | (32'(instr[20]) << 11)
             | (32'(instr[30:21]) << 1);
        e.rs1 = instr[19:15];
        e.rs2 = instr[24:20];
        e.rd  = instr[11:7];
        e.rd1 = readReg(instr[19:15], we, wrd, wres);
        e.rd2 = readReg(instr[24:20], we, wrd, wres);
        e.pc  = pc;
        e.pc4 = pc + 32'd4;
        case (instr[6:0])
            7'b0000011: begin
                e.regwrite = 1; e.resultsrc = 2'b01; e.alusrc = 1; e.imm = immI;
            end
            7'b0100011: begin
                e.memwrite = 1; e.alusrc = 1; e.imm = immS;
            end
            7'b0110011: begin
                e.regwrite = 1; e.aluctl = aluFromFunct(instr[14:12], instr[30]);
            end
            7'b0010011: begin
                e.regwrite = 1; e.alusrc = 1; e.imm = immI;
                e.aluctl = aluFromFunct(instr[14:12], 1'b0);
            end
            7'b1100011: begin
                e.branch = 1; e.imm = immB; e.aluctl = 3'b001;
            end
            7'b1101111: begin
                e.regwrite = 1; e.jump = 1; e.resultsrc = 2'b10; e.imm = immJ;
            end
            default: begin
            end
        endcase
        return e;
    endfunction

    task automatic checkAll(input expT e);
        check("regwriteE", 32'(bus.regwriteE), 32'(e.regwrite));
        check("resultsrcE", 32'(bus.resultsrcE), 32'(e.resultsrc));
        check("memwriteE", 32'(bus.memwriteE), 32'(e.memwrite));
        check("jumpE", 32'(bus.jumpE), 32'(e.jump));
        check("branchE", 32'(bus.branchE), 32'(e.branch));
        check("alucontrolE", 32'(bus.alucontrolE), 32'(e.aluctl));
        check("alusrcE", 32'(bus.alusrcE), 32'(e.alusrc));
        check("rd1E", bus.rd1E, e.rd1);
        check("rd2E", bus.rd2E, e.rd2);
        check("immextE", bus.immextE, e.imm);
        check("rs1E", 32'(bus.rs1E), 32'(e.rs1));
        check("rs2E", 32'(bus.rs2E), 32'(e.rs2));
        check("rdE", 32'(bus.rdE), 32'(e.rd));
        check("pcE", bus.pcE, e.pc);
        check("pcplus4E", bus.pcplus4E, e.pc4);
    endtask

    task automatic checkZero(input string tag);
        expT z;
        z = '0;
        check({tag, "Regwrite"}, 32'(bus.regwriteE), 32'(z.regwrite));
        check({tag, "Alusrc"}, 32'(bus.alusrcE), 32'(z.alusrc));
        check({tag, "Imm"}, bus.immextE, z.imm);
        check({tag, "Rd"}, 32'(bus.rdE), 32'(z.rd));
        check({tag, "Pc"}, bus.pcE, z.pc);
    endtask

    // One decode cycle: drive at negedge, check after the capturing edge, then commit writeback.
    task automatic step(input logic [31:0] instr, input logic flush, input logic we,
                        input logic [4:0] wrd, input logic [31:0] wres);
        expT         e;
        logic [31:0] pc;
        @(negedge clk);
        pc = $urandom() & 32'hFFFF_FFFC;
        bus.instrD    = instr;
        bus.pcD       = pc;
        bus.pcplus4D  = pc + 32'd4;
        bus.flushE    = flush;
        bus.regwriteW = we;
        bus.rdW       = wrd;
        bus.resultW   = wres;
        e = predict(instr, pc, flush, we, wrd, wres);
        @(posedge clk);
        #1;
        if (we && wrd != 5'd0) mregs[wrd] = wres;
        checkAll(e);
    endtask

    logic [6:0] opTable [8];

    initial begin
        logic [31:0] r;
        logic [31:0] instr;
        logic [31:0] wres;
        logic [4:0]  wrd;
        logic        we;
        logic        flush;

        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        opTable[0] = 7'b0000011; opTable[1] = 7'b0100011; opTable[2] = 7'b0110011;
        opTable[3] = 7'b0010011; opTable[4] = 7'b1100011; opTable[5] = 7'b1101111;
        opTable[6] = 7'b0000000; opTable[7] = 7'b1111111;

        rst           = 1'b0;
        bus.instrD    = 32'h00500093;
        bus.pcD       = 32'h100;
        bus.pcplus4D  = 32'h104;
        bus.flushE    = 1'b0;
        bus.regwriteW = 1'b0;
        bus.rdW       = 5'd0;
        bus.resultW   = 32'h0;

        // Held in reset across edges: outputs must stay cleared.
        #12;
        checkZero("inReset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkZero("afterRelease");
        @(posedge clk);
        #1;
        check("rstAddiRegwrite", 32'(bus.regwriteE), 32'd1);
        check("rstAddiAlusrc", 32'(bus.alusrcE), 32'd1);
        check("rstAddiImm", bus.immextE, 32'd5);
        check("rstAddiRd", 32'(bus.rdE), 32'd1);
        check("rstAddiAlu", 32'(bus.alucontrolE), 32'd0);
        check("rstAddiPc", bus.pcE, 32'h100);

        step(32'h00018133, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF);
        check("bypassRd1", bus.rd1E, 32'hDEADBEEF);

        step(32'h00000133, 1'b0, 1'b1, 5'd0, 32'h1234);
        check("x0SameCycle", bus.rd1E, 32'h0);
        step(32'h00000133, 1'b0, 1'b0, 5'd0, 32'h0);
        check("x0Read", bus.rd1E, 32'h0);

        step(32'hFE000EE3, 1'b0, 1'b0, 5'd0, 32'h0);
        check("beqBranch", 32'(bus.branchE), 32'd1);
        check("beqAlu", 32'(bus.alucontrolE), 32'd1);
        check("beqImm", bus.immextE, 32'hFFFFFFFC);
        step(32'hFE000EE3, 1'b1, 1'b0, 5'd0, 32'h0);
        check("flushBranch", 32'(bus.branchE), 32'd0);
        check("flushImm", bus.immextE, 32'd0);

        step(32'h40208033, 1'b0, 1'b0, 5'd0, 32'h0);
        check("subAlu", 32'(bus.alucontrolE), 32'd1);
        step(32'h0020A033, 1'b0, 1'b0, 5'd0, 32'h0);
        check("sltAlu", 32'(bus.alucontrolE), 32'd5);
        step(32'h008000EF, 1'b0, 1'b0, 5'd0, 32'h0);
        check("jalJump", 32'(bus.jumpE), 32'd1);
        check("jalResultsrc", 32'(bus.resultsrcE), 32'd2);
        check("jalImm", bus.immextE, 32'd8);

        // Asynchronous reset mid-cycle after x5 has been loaded.
        step(32'h00500093, 1'b0, 1'b1, 5'd5, 32'd7);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkZero("asyncRst");
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        @(negedge clk);
        bus.regwriteW = 1'b0;
        rst = 1'b1;
        step(32'h000280B3, 1'b0, 1'b0, 5'd0, 32'h0);
        check("x5Cleared", bus.rd1E, 32'h0);

        // Randomized phase
        for (int n = 0; n < 400; n++) begin
            r     = $urandom();
            instr = {r[31:7], opTable[$urandom_range(0, 7)]};
            if ($urandom_range(0, 7) == 0) instr[6:0] = 7'($urandom());
            r     = $urandom();
            we    = r[0];
            flush = (r[4:1] == 4'd0);
            wrd   = (r[6:5] == 2'd0) ? instr[19:15] : (r[6:5] == 2'd1) ? instr[24:20] : r[11:7];
            wres  = $urandom();
            step(instr, flush, we, wrd, wres);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
